multicycle_control_fsm: RTL and testbench

// - Sequencing controller for the multi-cycle RV32I core; replaces the single-cycle main/ALU decoder pair.
// - Drives the shared datapath: one memory port, one ALU, PC/IR/data registers.
// - Every instruction takes 3-5 states. Memory-facing states stall on a ready handshake.
// - Supported ops: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.

---
 rtl/multicycle_control_fsm.sv | 260 ++++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Purpose : sequencing controller for the multi-cycle RV32I core (shared memory port, ALU, PC/IR/data regs).
// Latency : lw 5, sw/R/I/jal 4, beq 3 cycles with MemReady=1; each MemReady-low cycle in FETCH/MEMREAD/MEMWRITE adds 1.
// Backpress: FETCH, MEMREAD and MEMWRITE hold (strobes held as decoded) until MemReady; elsewhere MemReady is ignored.
//
// Ports:
//   clk, rst (sync, active-high)   Op/funct3/funct7 from IR, Zero from ALU, MemReady from memory
//   PCWrite/AdrSrc/MemWrite/IRWrite/RegWrite/ResultSrc/ALUSrcA/ALUSrcB  datapath controls (Moore on State)
//   ImmSrc (combinational from Op), ALUControl, State (debug), Illegal (sticky illegal-opcode flag)
// Build option: define ILLEGAL_TRAP_EN to trap unsupported opcodes in TRAP (Illegal=1, exit only via rst);
//   without it unsupported opcodes fall back to FETCH as a nop and Illegal is tied 0.

module multicycle_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         Op,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic [2:0]         ALUControl,
    output logic [STATE_W-1:0] State,
    output logic               Illegal
);

    localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXECR    = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_EXECI    = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_BEQ      = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_TRAP     = STATE_W'(11);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_nxt;

    // Moore decode intermediates (before reset gating)
    logic       pcupdate;
    logic       branch;
    logic       memwrite_m;
    logic       irwrite_m;
    logic       regwrite_m;
    logic [1:0] aluop;

    // Only funct7[5] distinguishes sub from add; the other bits are don't-care here.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = S_FETCH;
        case (state_q)
            S_FETCH:    state_nxt = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXECR;
                    OP_I:         state_nxt = S_EXECI;
                    OP_JAL:       state_nxt = S_JAL;
                    OP_BEQ:       state_nxt = S_BEQ;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_nxt = S_TRAP;
`else
                    // PC was already advanced in FETCH, so dropping back is a nop.
                    default:      state_nxt = S_FETCH;
`endif
                endcase
            end
            // Only lw/sw reach MEMADR; anything that is not sw is treated as a load.
            S_MEMADR:   state_nxt = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_nxt = MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWRITE: state_nxt = MemReady ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_nxt = S_ALUWB;
            S_EXECI:    state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_JAL:      state_nxt = S_ALUWB;
            S_BEQ:      state_nxt = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     state_nxt = S_TRAP;
`else
            S_TRAP:     state_nxt = S_FETCH;
`endif
            default:    state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_nxt;
        end
    end

    assign State = state_q;

    // ------------------------------------------------------------------
    // Sticky illegal flag
    // ------------------------------------------------------------------
`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    // Set on the edge that enters TRAP so the flag is visible together with State=TRAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (state_nxt == S_TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    assign Illegal = illegal_q & ~rst;
`else
    assign Illegal = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        pcupdate   = 1'b0;
        branch     = 1'b0;
        AdrSrc     = 1'b0;
        memwrite_m = 1'b0;
        irwrite_m  = 1'b0;
        regwrite_m = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        aluop      = 2'b00;
        case (state_q)
            S_FETCH: begin
                // PC+4 and IR capture only once memory has returned the instruction.
                irwrite_m = MemReady;
                pcupdate  = MemReady;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                // Precompute the branch target while the register file is read.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                regwrite_m = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                memwrite_m = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                aluop   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regwrite_m = 1'b1;
            end
            S_JAL: begin
                // ALUOut = OldPC + 4 is the link value written back in ALUWB.
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                pcupdate = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                aluop   = 2'b01;
                branch  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Reset forces the strobes low combinationally so an abandoned instruction
    // cannot write during the reset cycles.
    assign PCWrite  = ~rst & (pcupdate | (branch & Zero));
    assign MemWrite = ~rst & memwrite_m;
    assign IRWrite  = ~rst & irwrite_m;
    assign RegWrite = ~rst & regwrite_m;

    // ------------------------------------------------------------------
    // ALU decoder
    // ------------------------------------------------------------------
    always_comb begin
        ALUControl = ALU_ADD;
        case (aluop)
            2'b00: ALUControl = ALU_ADD;
            2'b01: ALUControl = ALU_SUB;
            2'b10: begin
                case (funct3)
                    // Only R-type (Op[5]=1) with funct7[5]=1 is sub; addi ignores funct7.
                    3'b000:  ALUControl = ({Op[5], funct7[5]} == 2'b11) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

    // ------------------------------------------------------------------
    // Immediate format select
    // ------------------------------------------------------------------
    always_comb begin
        ImmSrc = 2'b00;
        case (Op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Purpose : directed self-checking bench for multicycle_control_fsm.
// Latency : checks every state cycle-by-cycle, including MemReady stalls.
// Backpress: drives MemReady low in FETCH/MEMREAD/MEMWRITE and in states where it must be ignored.

module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] Op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;
    logic       Illegal;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.STATE_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .Op         (Op),
        .funct3     (funct3),
        .funct7     (funct7),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .State      (State),
        .Illegal    (Illegal)
    );

    // {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}
    logic [17:0] ctl;
    assign ctl = {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUControl};

    localparam logic [17:0] V_FETCH    = {4'd0,  5'b10010, 2'b10, 2'b00, 2'b10, 3'b000};
    localparam logic [17:0] V_FSTALL   = {4'd0,  5'b00000, 2'b10, 2'b00, 2'b10, 3'b000};
    localparam logic [17:0] V_DECODE   = {4'd1,  5'b00000, 2'b00, 2'b01, 2'b01, 3'b000};
    localparam logic [17:0] V_MEMADR   = {4'd2,  5'b00000, 2'b00, 2'b10, 2'b01, 3'b000};
    localparam logic [17:0] V_MEMREAD  = {4'd3,  5'b01000, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [17:0] V_MEMWB    = {4'd4,  5'b00001, 2'b01, 2'b00, 2'b00, 3'b000};
    localparam logic [17:0] V_MEMWRITE = {4'd5,  5'b01100, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [17:0] V_ALUWB    = {4'd7,  5'b00001, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [17:0] V_JAL      = {4'd9,  5'b10000, 2'b00, 2'b01, 2'b10, 3'b000};
    localparam logic [17:0] V_BEQ_T    = {4'd10, 5'b10000, 2'b00, 2'b10, 2'b00, 3'b001};
    localparam logic [17:0] V_BEQ_NT   = {4'd10, 5'b00000, 2'b00, 2'b10, 2'b00, 3'b001};
    localparam logic [17:0] V_TRAP     = {4'd11, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b000};

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
    task automatic test_reset;
        rst = 1'b1; Op = 7'b0000011; funct3 = 3'b000; funct7 = 7'b0000000;
        Zero = 1'b0; MemReady = 1'b1;
        @(posedge clk); #2;
        n_cmp++;
        if ({PCWrite, MemWrite, IRWrite, RegWrite, Illegal} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_strobes got=%b want=00000",
                     {PCWrite, MemWrite, IRWrite, RegWrite, Illegal});
        end
        @(posedge clk); #1;
        rst = 1'b0; #1;
        n_cmp++;
        if (ctl !== V_FETCH) begin
            n_err++;
            $display("FAIL reset_fetch got=%h want=%h", ctl, V_FETCH);
        end
    endtask

    task automatic test_lw;
        logic [17:0] e [5];
        e = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMWB};
        Op = 7'b0000011; MemReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if (ctl !== e[i]) begin
                n_err++;
                $display("FAIL lw cyc%0d got=%h want=%h", i, ctl, e[i]);
            end
            if (i == 0) begin
                n_cmp++;
                if (ImmSrc !== 2'b00) begin
                    n_err++;
                    $display("FAIL lw_immsrc got=%b want=00", ImmSrc);
                end
            end
            @(posedge clk);
        end
        #1;
        n_cmp++;
        if (State !== 4'd0) begin
            n_err++;
            $display("FAIL lw_done got=%0d want=0", State);
        end
    endtask

    task automatic test_lw_stalls;
        logic [17:0] e [8];
        logic        mr [8];
        e  = '{V_FSTALL, V_FSTALL, V_FETCH, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMREAD, V_MEMWB};
        mr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        Op = 7'b0000011;
        for (int i = 0; i < 8; i++) begin
            MemReady = mr[i]; #1;
            n_cmp++;
            if (ctl !== e[i]) begin
                n_err++;
                $display("FAIL lw_stall cyc%0d got=%h want=%h", i, ctl, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_stall;
        logic [17:0] e [7];
        logic        mr [7];
        int          wr_cnt;
        // MemReady low in DECODE/MEMADR must be ignored; 3 stall cycles in MEMWRITE.
        e  = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWRITE, V_MEMWRITE, V_MEMWRITE, V_MEMWRITE};
        mr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        wr_cnt = 0;
        Op = 7'b0100011;
        for (int i = 0; i < 7; i++) begin
            MemReady = mr[i]; #1;
            n_cmp++;
            if (ctl !== e[i]) begin
                n_err++;
                $display("FAIL sw cyc%0d got=%h want=%h", i, ctl, e[i]);
            end
            if (MemWrite === 1'b1) wr_cnt++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (wr_cnt !== 4) begin
            n_err++;
            $display("FAIL sw_memwrite_cycles got=%0d want=4", wr_cnt);
        end
        MemReady = 1'b1; #1;
        n_cmp++;
        if (ctl !== V_FETCH || ImmSrc !== 2'b01) begin
            n_err++;
            $display("FAIL sw_done got=%h/%b want=%h/01", ctl, ImmSrc, V_FETCH);
        end
    endtask

    task automatic test_rtype;
        logic [2:0] f3  [4];
        logic [6:0] f7  [4];
        logic [2:0] alu [4];
        logic [17:0] e [4];
        f3  = '{3'b000, 3'b111, 3'b010, 3'b000};
        f7  = '{7'b0100000, 7'b0000000, 7'b0000000, 7'b0000000};
        alu = '{3'b001, 3'b010, 3'b101, 3'b000};
        Op = 7'b0110011; MemReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            funct3 = f3[k]; funct7 = f7[k];
            e = '{V_FETCH, V_DECODE, {4'd6, 5'b00000, 2'b00, 2'b10, 2'b00, alu[k]}, V_ALUWB};
            for (int i = 0; i < 4; i++) begin
                #1;
                n_cmp++;
                if (ctl !== e[i]) begin
                    n_err++;
                    $display("FAIL rtype%0d cyc%0d got=%h want=%h", k, i, ctl, e[i]);
                end
                @(posedge clk);
            end
        end
        #1;
    endtask

    task automatic test_itype;
        logic [2:0] f3  [3];
        logic [2:0] alu [3];
        logic [17:0] e [4];
        // funct7[5]=1 on addi must still add (Op[5]=0).
        f3  = '{3'b000, 3'b110, 3'b001};
        alu = '{3'b000, 3'b011, 3'b000};
        Op = 7'b0010011; funct7 = 7'b0100000; MemReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            funct3 = f3[k];
            e = '{V_FETCH, V_DECODE, {4'd8, 5'b00000, 2'b00, 2'b10, 2'b01, alu[k]}, V_ALUWB};
            for (int i = 0; i < 4; i++) begin
                #1;
                n_cmp++;
                if (ctl !== e[i]) begin
                    n_err++;
                    $display("FAIL itype%0d cyc%0d got=%h want=%h", k, i, ctl, e[i]);
                end
                @(posedge clk);
            end
        end
        #1;
    endtask

    task automatic test_beq;
        logic [17:0] e [3];
        Op = 7'b1100011; funct3 = 3'b000; funct7 = 7'b0000000; MemReady = 1'b1;
        for (int k = 0; k < 2; k++) begin
            Zero = (k == 0) ? 1'b1 : 1'b0;
            e = '{V_FETCH, V_DECODE, (k == 0) ? V_BEQ_T : V_BEQ_NT};
            for (int i = 0; i < 3; i++) begin
                #1;
                n_cmp++;
                if (ctl !== e[i]) begin
                    n_err++;
                    $display("FAIL beq_z%0d cyc%0d got=%h want=%h", 1 - k, i, ctl, e[i]);
                end
                @(posedge clk);
            end
            #1;
            n_cmp++;
            if (State !== 4'd0 || ImmSrc !== 2'b10) begin
                n_err++;
                $display("FAIL beq_done got=%0d/%b want=0/10", State, ImmSrc);
            end
        end
        Zero = 1'b0;
    endtask

    task automatic test_jal;
        logic [17:0] e [4];
        e = '{V_FETCH, V_DECODE, V_JAL, V_ALUWB};
        Op = 7'b1101111; MemReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (ctl !== e[i]) begin
                n_err++;
                $display("FAIL jal cyc%0d got=%h want=%h", i, ctl, e[i]);
            end
            @(posedge clk);
        end
        #1;
        n_cmp++;
        if (State !== 4'd0 || ImmSrc !== 2'b11) begin
            n_err++;
            $display("FAIL jal_done got=%0d/%b want=0/11", State, ImmSrc);
        end
    endtask

    task automatic test_illegal;
        Op = 7'b1111111; MemReady = 1'b1; #1;
        n_cmp++;
        if (ctl !== V_FETCH || ImmSrc !== 2'b00) begin
            n_err++;
            $display("FAIL ill_fetch got=%h/%b want=%h/00", ctl, ImmSrc, V_FETCH);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (ctl !== V_DECODE || Illegal !== 1'b0) begin
            n_err++;
            $display("FAIL ill_decode got=%h/%b want=%h/0", ctl, Illegal, V_DECODE);
        end
        @(posedge clk); #1;
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            MemReady = i[0]; #1;
            n_cmp++;
            if (ctl !== V_TRAP || Illegal !== 1'b1) begin
                n_err++;
                $display("FAIL ill_trap cyc%0d got=%h/%b want=%h/1", i, ctl, Illegal, V_TRAP);
            end
            @(posedge clk); #1;
        end
`else
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if (ctl !== ((i == 0) ? V_FETCH : V_DECODE) || Illegal !== 1'b0) begin
                n_err++;
                $display("FAIL ill_nop cyc%0d got=%h/%b want_state=%0d/0", i, ctl, Illegal, i);
            end
            @(posedge clk); #1;
        end
`endif
        // Reset out of whatever state remains.
        rst = 1'b1; #1;
        n_cmp++;
        if (Illegal !== 1'b0) begin
            n_err++;
            $display("FAIL ill_rst got=%b want=0", Illegal);
        end
        @(posedge clk); #1;
        rst = 1'b0; Op = 7'b0000011; #1;
        n_cmp++;
        if (ctl !== V_FETCH || Illegal !== 1'b0) begin
            n_err++;
            $display("FAIL ill_after_rst got=%h/%b want=%h/0", ctl, Illegal, V_FETCH);
        end
    endtask

    task automatic test_reset_midwrite;
        Op = 7'b0100011; MemReady = 1'b1;
        @(posedge clk); #1;             // DECODE
        MemReady = 1'b0;
        @(posedge clk); #1;             // MEMADR
        @(posedge clk); #1;             // MEMWRITE, stalled
        #1;
        n_cmp++;
        if (ctl !== V_MEMWRITE) begin
            n_err++;
            $display("FAIL rstmw_pre got=%h want=%h", ctl, V_MEMWRITE);
        end
        rst = 1'b1; #1;
        n_cmp++;
        if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0000) begin
            n_err++;
            $display("FAIL rstmw_rst1 strobes got=%b want=0000",
                     {PCWrite, MemWrite, IRWrite, RegWrite});
        end
        @(posedge clk); #2;
        n_cmp++;
        if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0000 || State !== 4'd0) begin
            n_err++;
            $display("FAIL rstmw_rst2 got=%b/%0d want=0000/0",
                     {PCWrite, MemWrite, IRWrite, RegWrite}, State);
        end
        @(posedge clk); #1;
        rst = 1'b0; MemReady = 1'b1; #1;
        n_cmp++;
        if (ctl !== V_FETCH) begin
            n_err++;
            $display("FAIL rstmw_after got=%h want=%h", ctl, V_FETCH);
        end
        @(posedge clk); #2;
        n_cmp++;
        if (ctl !== V_DECODE) begin
            n_err++;
            $display("FAIL rstmw_decode got=%h want=%h", ctl, V_DECODE);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lw_stalls();
        test_sw_stall();
        test_rtype();
        test_itype();
        test_beq();
        test_jal();
        test_illegal();
        test_reset_midwrite();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
